// File: rtl/uart_tx_fifo.sv
// Byte-wide UART transmitter with a small FIFO, 8N1 LSB-first, idle-high line.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frame).
module uart_tx_fifo #(
  parameter int unsigned CLK_DIV = 434,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_in,
  input  logic       tx_write,
  output logic       tx,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       overflow
);
  localparam int unsigned       DEPTH    = 1 << FIFO_AW;
  localparam logic [15:0]       BIT_LOAD = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0]  FULL_CNT = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e               state_q, state_d;
  logic                 wr_q;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_AW-1:0]   wptr_q, rptr_q;
  logic [FIFO_AW:0]     count_q;
  logic                 overflow_q;
  logic [15:0]          timer_q, timer_d;
  logic [2:0]           bitcnt_q, bitcnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 push, push_ok, pop;
  logic [7:0]           head;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign push      = tx_write & ~wr_q;
  assign fifo_full = (count_q == FULL_CNT);
  // Full is judged on the registered count, so a same-cycle pop cannot admit a push.
  assign push_ok   = push & ~fifo_full;
  assign head      = mem[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_q <= tx_write;
      if (push_ok)           wptr_q     <= wptr_q + 1'b1;
      if (pop)               rptr_q     <= rptr_q + 1'b1;
      if (push && fifo_full) overflow_q <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= tx_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          timer_d = BIT_LOAD;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      START: begin
        if (timer_q == '0) begin
          state_d  = DATA;
          timer_d  = BIT_LOAD;
          bitcnt_d = '0;
          tx_d     = shift_q[0];
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          timer_d = BIT_LOAD;
          if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
            shift_d  = {1'b0, shift_q[7:1]};
            tx_d     = shift_q[1];
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (timer_q == '0) begin
          state_d = STOP;
          timer_d = BIT_LOAD;
          tx_d    = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`endif
      STOP: begin
        if (timer_q == '0) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
            timer_d = BIT_LOAD;
            tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx       = tx_q;
  assign tx_busy  = (state_q != IDLE) | (count_q != '0);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench for uart_tx_fifo: a line monitor decodes frames and checks them
// against bytes queued when accepted pushes are driven.
module tb_uart_tx_fifo;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned FIFO_AW = 2;
  localparam int HALF = CLK_DIV / 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_in = '0;
  logic       tx_write = 1'b0;
  logic       tx, tx_busy, fifo_full, overflow;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [$];
  int         cyc = 0;
  bit         in_frame = 1'b0;
  int         off = 0;
  int         nframes = 0;
  int         last_start = 0;
  int         prev_start = 0;
  logic [7:0] rx_byte = '0;
  logic       rx_par = 1'b0;
  logic [7:0] e;

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst_n(rst_n), .tx_in(tx_in), .tx_write(tx_write),
    .tx(tx), .tx_busy(tx_busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Line monitor: off counts clk cycles since the start bit was first seen low.
  initial forever begin
    @(negedge clk);
    if (!rst_n) in_frame = 1'b0;
    else if (!in_frame) begin
      if (tx === 1'b0) begin
        in_frame   = 1'b1;
        off        = 0;
        prev_start = last_start;
        last_start = cyc;
      end
    end else off++;
    if (in_frame && rst_n) begin
      if (off == HALF) check_eq("start_bit", 32'(tx), 32'd0);
      for (int i = 0; i < 8; i++)
        if (off == CLK_DIV * (1 + i) + HALF) rx_byte[i] = tx;
`ifdef UART_TX_PARITY_EN
      if (off == CLK_DIV * 9 + HALF) rx_par = tx;
`endif
      if (off == FRAME - CLK_DIV + HALF) begin
        check_eq("stop_bit", 32'(tx), 32'd1);
        nframes++;
        if (exp_q.size() == 0) check_eq("unexpected_frame", 32'(rx_byte), 32'h100);
        else begin
          e = exp_q.pop_front();
          check_eq("rx_byte", 32'(rx_byte), 32'(e));
`ifdef UART_TX_PARITY_EN
          check_eq("parity", 32'(rx_par), 32'(^e));
`endif
        end
      end
      if (off == FRAME - 1) in_frame = 1'b0;
    end
  end

  task automatic push(input logic [7:0] b, input int hold, input bit accept);
    @(negedge clk);
    tx_in    = b;
    tx_write = 1'b1;
    if (accept) exp_q.push_back(b);
    repeat (hold) @(negedge clk);
    tx_write = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((tx_busy !== 1'b0 || in_frame) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("idle_reached", 32'(n < budget), 32'd1);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int f0;
    bit found;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(tx_busy), 32'd0);
    check_eq("rst_full", 32'(fifo_full), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single byte: latency and frame length
    @(negedge clk);
    tx_in = 8'h55; tx_write = 1'b1; exp_q.push_back(8'h55);
    @(negedge clk);
    tx_write = 1'b0;
    check_eq("t1_tx_before", 32'(tx), 32'd1);
    @(negedge clk);
    check_eq("t1_tx_low", 32'(tx), 32'd0);
    repeat (FRAME - 1) @(negedge clk);
    check_eq("t1_busy_end", 32'(tx_busy), 32'd1);
    @(negedge clk);
    check_eq("t1_busy_low", 32'(tx_busy), 32'd0);
    wait_idle(200);

    // held strobe enqueues once
    f0 = nframes;
    push(8'hA3, 100, 1'b1);
    wait_idle(400);
    check_eq("t2_frames", 32'(nframes - f0), 32'd1);

    // back-to-back frames
    f0 = nframes;
    push(8'h01, 1, 1'b1);
    push(8'h80, 1, 1'b1);
    wait_idle(300);
    check_eq("t3_frames", 32'(nframes - f0), 32'd2);
    check_eq("t3_gap", 32'(last_start - prev_start), 32'(FRAME));

    // fill and overflow
    f0 = nframes;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i), 1, 1'b1);
    check_eq("t4_full", 32'(fifo_full), 32'd1);
    check_eq("t4_no_ovf_yet", 32'(overflow), 32'd0);
    push(8'h15, 1, 1'b0);
    check_eq("t4_ovf", 32'(overflow), 32'd1);
    check_eq("t4_full_kept", 32'(fifo_full), 32'd1);
    wait_idle(600);
    check_eq("t4_frames", 32'(nframes - f0), 32'd5);
    check_eq("t4_ovf_sticky", 32'(overflow), 32'd1);
    check_eq("t4_full_clear", 32'(fifo_full), 32'd0);

    // reset during data bit 3 with two bytes queued
    f0 = nframes;
    push(8'h3C, 1, 1'b1);
    push(8'hC3, 1, 1'b1);
    push(8'h5A, 1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      #1;
      if (in_frame && off == CLK_DIV * 4 + 1) found = 1'b1;
    end
    check_eq("t5_reached_bit3", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_tx", 32'(tx), 32'd1);
    check_eq("t5_busy", 32'(tx_busy), 32'd0);
    check_eq("t5_full", 32'(fifo_full), 32'd0);
    check_eq("t5_ovf", 32'(overflow), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check_eq("t5_no_frames", 32'(nframes - f0), 32'd0);
    check_eq("t5_tx_idle", 32'(tx), 32'd1);
    check_eq("t5_busy_idle", 32'(tx_busy), 32'd0);

    // parity patterns (parity bit checked by the monitor when enabled)
    f0 = nframes;
    push(8'h07, 1, 1'b1);
    push(8'h03, 1, 1'b1);
    wait_idle(300);
    check_eq("t6_frames", 32'(nframes - f0), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
